axi_lite_mem_arbiter: RTL and testbench
=======================================

// Module: axi_lite_mem_arbiter
// PURPOSE
//  Shares the single AXI-lite SRAM slave port between the IFU (read-only master M0) and the LSU
//  (read/write master M1). It sits between the core's fetch/load-store units and the memory.
//  Only one transaction is in flight at a time. Arbitration is round-robin or fixed-priority.
//  The data path is a combinational mux steered by a registered grant FSM.
// PARAMETERS
//  DATA_W    32  address and data width; equals `CPU_WIDTH
//  ARB_MODE  0   0 = round-robin IFU/LSU; 1 = fixed priority, LSU always wins
// PORTS
//  i_clk                          in   1          system clock, rising edge
//  i_rst                          in   1          asynchronous reset, active-high
//  m0_araddr/arvalid/arready      in/in/out      DATA_W/1/1           IFU AR channel
//  m0_rdata/rresp/rvalid/rready   out/out/out/in DATA_W/2/1/1         IFU R channel
//  m1_awaddr/awvalid/awready      in/in/out      DATA_W/1/1           LSU AW channel
//  m1_wdata/wstrb/wvalid/wready   in/in/in/out   DATA_W/DATA_W/8/1/1  LSU W channel
//  m1_bresp/bvalid/bready         out/out/in     2/1/1                LSU B channel
//  m1_araddr/arvalid/arready      in/in/out      DATA_W/1/1           LSU AR channel
//  m1_rdata/rresp/rvalid/rready   out/out/out/in DATA_W/2/1/1         LSU R channel
//  s_aw*/s_w*/s_b*/s_ar*/s_r*     mirrored       as above             slave-side AXI-lite to SRAM
//  o_grant                        out  2          00 none, 01 IFU read, 10 LSU read, 11 LSU write
// BEHAVIOUR
//  - FSM states: IDLE, IF_RD, LS_RD, LS_WR. State, last_grant and the ar/aw/w done flags are registers.
//  - Reset (async, i_rst=1):
//    - state=IDLE, last_grant=LSU (so IFU wins the first tie), all done flags cleared.
//    - All valid/ready outputs on both sides are 0 while in reset; o_grant=00.
//  - IDLE requests:
//    - rq_if = m0_arvalid
//    - rq_lr = m1_arvalid
//    - rq_lw = m1_awvalid & m1_wvalid; a write needs both AW and W valid.
//  - LSU internal priority: write beats read when both are asserted.
//  - IFU vs LSU resolution:
//    - ARB_MODE=0: winner is the requester not equal to last_grant.
//    - ARB_MODE=1: LSU always wins.
//    - A single requester always wins.
//  - Grant latency: the grant is registered. The request seen in IDLE at edge N gives forwarding from cycle N+1.
//  - No slave signal is driven from IDLE: all s_*valid=0, s_rready=0, s_bready=0.
//  - IF_RD:
//    - s_ar* = m0_ar*, gated by !ar_done; ar_done sets on s_arvalid & s_arready.
//    - Then s_rready = m0_rready and m0_r* = s_r*.
//    - Exit to IDLE on s_rvalid & s_rready; last_grant <= IFU.
//  - LS_RD: same as IF_RD using m1_ar*/m1_r*. On exit, last_grant <= LSU.
//  - LS_WR:
//    - s_aw* is forwarded until aw_done; s_w* is forwarded until w_done. Each flag sets on its handshake.
//    - s_bready = m1_bready; m1_b* = s_b*.
//    - Exit on the B handshake; last_grant <= LSU.
//  - Non-granted channels: ready/valid outputs forced to 0; their addr/data outputs are don't-care.
//    - Addr/data outputs are driven from the granted master to limit toggling.
//  - A master that drops valid before its handshake is a protocol violation.
//    - The FSM holds its state; there is no timeout.
//  - Mid-operation reset: async return to IDLE. The in-flight transaction is abandoned; the slave is reset in step.
//  - Back-to-back: after exit, IDLE takes >=1 cycle before the next grant. Worst-case turnaround is 1 bubble.
//  - A new request arriving in the same cycle as the exit handshake is granted at the next edge.
//  - Response fields rresp/bresp pass through unchanged; the arbiter generates no errors.
// TESTING
//  - Reset: hold i_rst=1 with all master valids=1 -> every ready/valid output 0, o_grant=00.
//    - First edge after release: o_grant=01.
//  - IFU-only read: m0 addr 0x8000_0000, slave returns 0xDEADBEEF -> m0_rdata=0xDEADBEEF, m0_rvalid for 1 cycle.
//    - m1_* outputs stay 0 throughout.
//  - Round-robin tie (ARB_MODE=0): m0 and m1 reads held continuously.
//    - Grants alternate 01,10,01,10 across 4 transactions.
//  - Fixed priority (ARB_MODE=1): same stimulus -> o_grant=10 for all 4; IFU starved.
//  - LSU write: AW 0x8000_0010, W 0x12345678, wstrb 4'b0011.
//    - Slave sees both at once; m1_bvalid=1 with bresp=00; o_grant=11 until the B handshake.
//    - With m1_bready delayed 3 cycles, the arbiter holds LS_WR for those cycles.
//  - Reset mid-read: assert i_rst in IF_RD after the AR handshake.
//    - Outputs are 0 the same cycle; after release, a fresh LSU read completes normally.

Source files
------------

// File: rtl/axi_lite_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_lite_mem_arbiter
// Description : Shares one AXI-lite SRAM slave port between the IFU (M0,
//               read-only) and the LSU (M1, read/write). One transaction is
//               in flight at a time. A registered grant FSM steers a purely
//               combinational channel mux. Arbitration is either round-robin
//               (ARB_MODE=0) or fixed priority with the LSU winning
//               (ARB_MODE=1).
// Ports       : i_clk, i_rst        - clock, async active-high reset
//               m0_ar*, m0_r*       - IFU read address / read data
//               m1_aw*, m1_w*, m1_b*- LSU write address / data / response
//               m1_ar*, m1_r*       - LSU read address / read data
//               s_*                 - slave-side AXI-lite towards the SRAM
//               o_grant             - 00 none, 01 IFU rd, 10 LSU rd, 11 LSU wr
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_mem_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ARB_MODE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   // IFU read channels
   input  logic [DATA_W-1:0]     m0_araddr,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   // LSU write channels
   input  logic [DATA_W-1:0]     m1_awaddr,
   input  logic                  m1_awvalid,
   output logic                  m1_awready,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   input  logic                  m1_wvalid,
   output logic                  m1_wready,
   output logic [1:0]            m1_bresp,
   output logic                  m1_bvalid,
   input  logic                  m1_bready,
   // LSU read channels
   input  logic [DATA_W-1:0]     m1_araddr,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   // Slave side
   output logic [DATA_W-1:0]     s_awaddr,
   output logic                  s_awvalid,
   input  logic                  s_awready,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   output logic                  s_wvalid,
   input  logic                  s_wready,
   input  logic [1:0]            s_bresp,
   input  logic                  s_bvalid,
   output logic                  s_bready,
   output logic [DATA_W-1:0]     s_araddr,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   // Grant status
   output logic [1:0]            o_grant
);

   // State encoding doubles as the o_grant code.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      IF_RD = 2'b01,
      LS_RD = 2'b10,
      LS_WR = 2'b11
   } state_t;

   localparam logic c_LG_IFU = 1'b0;
   localparam logic c_LG_LSU = 1'b1;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_last_grant;
   logic   w_last_grant_nxt;
   logic   r_ar_done;
   logic   r_aw_done;
   logic   r_w_done;

   logic   w_rq_if;
   logic   w_rq_lr;
   logic   w_rq_lw;
   logic   w_rq_ls;
   logic   w_if_wins;
   logic   w_wr_accepted;

   assign w_rq_if = m0_arvalid;
   assign w_rq_lr = m1_arvalid;
   assign w_rq_lw = m1_awvalid & m1_wvalid;
   assign w_rq_ls = w_rq_lr | w_rq_lw;

   // On an IFU/LSU tie: round-robin favours whoever was not served last;
   // fixed priority always hands the port to the LSU.
   assign w_if_wins = (ARB_MODE == 0) ? (r_last_grant == c_LG_LSU) : 1'b0;

   // B may only be relayed once both halves of the write were accepted.
   assign w_wr_accepted = r_aw_done & r_w_done;

   assign o_grant = r_state;

   // -------------------------------------------------------------------------
   // State, last grant and per-channel done flags
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_last_grant <= c_LG_LSU;
         r_ar_done    <= 1'b0;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
         if (w_state_nxt == IDLE) begin
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (s_arvalid && s_arready) r_ar_done <= 1'b1;
            if (s_awvalid && s_awready) r_aw_done <= 1'b1;
            if (s_wvalid  && s_wready)  r_w_done  <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and channel steering
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;

      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = 2'b00;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = 2'b00;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = 2'b00;

      s_awvalid  = 1'b0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      // Address/data follow the LSU unless the IFU owns the read port, so
      // slave-side buses only toggle with the master actually granted.
      s_araddr   = m1_araddr;
      s_awaddr   = m1_awaddr;
      s_wdata    = m1_wdata;
      s_wstrb    = m1_wstrb;

      case (r_state)
         IDLE: begin
            if (w_rq_if && (!w_rq_ls || w_if_wins)) begin
               w_state_nxt = IF_RD;
            end else if (w_rq_lw) begin
               w_state_nxt = LS_WR;
            end else if (w_rq_lr) begin
               w_state_nxt = LS_RD;
            end
         end

         IF_RD: begin
            s_araddr   = m0_araddr;
            s_arvalid  = m0_arvalid & ~r_ar_done;
            m0_arready = s_arready  & ~r_ar_done;
            s_rready   = m0_rready  & r_ar_done;
            m0_rvalid  = s_rvalid   & r_ar_done;
            m0_rdata   = s_rdata;
            m0_rresp   = s_rresp;
            if (r_ar_done && s_rvalid && m0_rready) begin
               w_state_nxt      = IDLE;
               w_last_grant_nxt = c_LG_IFU;
            end
         end

         LS_RD: begin
            s_arvalid  = m1_arvalid & ~r_ar_done;
            m1_arready = s_arready  & ~r_ar_done;
            s_rready   = m1_rready  & r_ar_done;
            m1_rvalid  = s_rvalid   & r_ar_done;
            m1_rdata   = s_rdata;
            m1_rresp   = s_rresp;
            if (r_ar_done && s_rvalid && m1_rready) begin
               w_state_nxt      = IDLE;
               w_last_grant_nxt = c_LG_LSU;
            end
         end

         LS_WR: begin
            s_awvalid  = m1_awvalid & ~r_aw_done;
            m1_awready = s_awready  & ~r_aw_done;
            s_wvalid   = m1_wvalid  & ~r_w_done;
            m1_wready  = s_wready   & ~r_w_done;
            s_bready   = m1_bready  & w_wr_accepted;
            m1_bvalid  = s_bvalid   & w_wr_accepted;
            m1_bresp   = s_bresp;
            if (w_wr_accepted && s_bvalid && m1_bready) begin
               w_state_nxt      = IDLE;
               w_last_grant_nxt = c_LG_LSU;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_mem_arbiter
// Description : Directed self-checking bench. Two arbiters (round-robin and
//               fixed priority) share the master-side stimulus; each has its
//               own simple AXI-lite SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Shared master-side inputs
   logic [31:0] m0_araddr;
   logic        m0_arvalid;
   logic        m0_rready;
   logic [31:0] m1_awaddr;
   logic        m1_awvalid;
   logic [31:0] m1_wdata;
   logic [3:0]  m1_wstrb;
   logic        m1_wvalid;
   logic        m1_bready;
   logic [31:0] m1_araddr;
   logic        m1_arvalid;
   logic        m1_rready;

   // g_dut[0]: ARB_MODE=0, g_dut[1]: ARB_MODE=1
   for (genvar k = 0; k < 2; k++) begin : g_dut
      logic        m0_arready, m0_rvalid;
      logic [31:0] m0_rdata;
      logic [1:0]  m0_rresp;
      logic        m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
      logic [1:0]  m1_bresp, m1_rresp;
      logic [31:0] m1_rdata;
      logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
      logic [3:0]  s_wstrb;
      logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
      logic        s_bvalid, s_rvalid;
      logic [1:0]  s_bresp, s_rresp;
      logic        s_awready, s_wready, s_arready;
      logic [1:0]  grant;
      logic [11:0] vr;
      logic        aw_hs, w_hs, aw_seen, w_seen;
      logic [31:0] cap_awaddr, cap_wdata;
      logic [3:0]  cap_wstrb;

      assign s_awready = 1'b1;
      assign s_wready  = 1'b1;
      assign s_arready = 1'b1;
      assign aw_hs     = s_awvalid & s_awready;
      assign w_hs      = s_wvalid & s_wready;
      assign vr = {m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid,
                   m1_arready, m1_rvalid, s_awvalid, s_wvalid, s_bready,
                   s_arvalid, s_rready};

      axi_lite_mem_arbiter #(.DATA_W(32), .ARB_MODE(k)) u_dut (
         .i_clk(clk), .i_rst(rst),
         .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
         .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
         .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
         .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
         .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
         .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
         .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
         .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
         .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
         .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
         .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
         .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
         .o_grant(grant)
      );

      // SRAM responder: R one cycle after AR; B once both AW and W are in.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s_rvalid   <= 1'b0;
            s_rdata    <= '0;
            s_rresp    <= 2'b00;
            s_bvalid   <= 1'b0;
            s_bresp    <= 2'b00;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
            cap_awaddr <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
         end else begin
            if (s_arvalid && s_arready) begin
               s_rvalid <= 1'b1;
               s_rdata  <= (s_araddr == 32'h8000_0000) ? 32'hDEAD_BEEF : ~s_araddr;
               s_rresp  <= (s_araddr == 32'h8000_0000) ? 2'b00 : 2'b01;
            end else if (s_rvalid && s_rready) begin
               s_rvalid <= 1'b0;
            end
            if (s_bvalid && s_bready) begin
               s_bvalid <= 1'b0;
               aw_seen  <= 1'b0;
               w_seen   <= 1'b0;
            end else begin
               if (aw_hs) begin
                  aw_seen    <= 1'b1;
                  cap_awaddr <= s_awaddr;
               end
               if (w_hs) begin
                  w_seen    <= 1'b1;
                  cap_wdata <= s_wdata;
                  cap_wstrb <= s_wstrb;
               end
               if ((aw_seen || aw_hs) && (w_seen || w_hs)) s_bvalid <= 1'b1;
            end
         end
      end
   end

   // Bookkeeping
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        hold_rd;
   int          m0_rv_cnt, m1_rv_cnt, m1_bv_cnt, wr_gnt_cnt, b_stall;
   logic [31:0] m0_rdata_obs, m1_rdata_obs, ar_addr_obs;
   logic [1:0]  m0_rresp_obs, m1_rresp_obs, bresp_obs;
   logic        m0_r_done, m1_r_done, m1_b_done, both_seen, m1_act;
   logic [1:0]  gh0 [8];
   logic [1:0]  gh1 [8];
   int          gn0, gn1;
   logic [1:0]  prev_g0, prev_g1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      m0_rv_cnt = 0; m1_rv_cnt = 0; m1_bv_cnt = 0; wr_gnt_cnt = 0; b_stall = 0;
      m0_rdata_obs = '0; m1_rdata_obs = '0; ar_addr_obs = '0;
      m0_rresp_obs = 2'b11; m1_rresp_obs = 2'b11; bresp_obs = 2'b11;
      m0_r_done = 1'b0; m1_r_done = 1'b0; m1_b_done = 1'b0;
      both_seen = 1'b0; m1_act = 1'b0;
      gn0 = 0; gn1 = 0; prev_g0 = 2'b00; prev_g1 = 2'b00;
      for (int i = 0; i < 8; i++) begin
         gh0[i] = 2'b00;
         gh1[i] = 2'b00;
      end
   endtask

   // One clock: observe at the falling edge, then let the masters drop any
   // valid that was accepted (unless reads are being held continuously).
   task automatic step();
      logic hs_m0ar, hs_m1ar, hs_aw, hs_w;
      @(negedge clk);
      hs_m0ar = m0_arvalid & g_dut[0].m0_arready;
      hs_m1ar = m1_arvalid & g_dut[0].m1_arready;
      hs_aw   = m1_awvalid & g_dut[0].m1_awready;
      hs_w    = m1_wvalid  & g_dut[0].m1_wready;
      if (g_dut[0].m0_rvalid) begin
         m0_rv_cnt++;
         m0_rdata_obs = g_dut[0].m0_rdata;
         m0_rresp_obs = g_dut[0].m0_rresp;
         if (m0_rready) m0_r_done = 1'b1;
      end
      if (g_dut[0].m1_rvalid) begin
         m1_rv_cnt++;
         m1_rdata_obs = g_dut[0].m1_rdata;
         m1_rresp_obs = g_dut[0].m1_rresp;
         if (m1_rready) m1_r_done = 1'b1;
      end
      if (g_dut[0].m1_bvalid) begin
         m1_bv_cnt++;
         bresp_obs = g_dut[0].m1_bresp;
         if (m1_bready) m1_b_done = 1'b1;
         else b_stall++;
      end
      if (g_dut[0].grant == 2'b11) wr_gnt_cnt++;
      if (g_dut[0].s_awvalid && g_dut[0].s_wvalid) both_seen = 1'b1;
      if (g_dut[0].s_arvalid) ar_addr_obs = g_dut[0].s_araddr;
      m1_act = m1_act | g_dut[0].m1_arready | g_dut[0].m1_rvalid | g_dut[0].m1_awready
             | g_dut[0].m1_wready | g_dut[0].m1_bvalid | (|g_dut[0].m1_rdata)
             | (|g_dut[0].m1_rresp) | (|g_dut[0].m1_bresp);
      if (g_dut[0].grant != 2'b00 && prev_g0 == 2'b00 && gn0 < 8) begin
         gh0[gn0] = g_dut[0].grant;
         gn0++;
      end
      if (g_dut[1].grant != 2'b00 && prev_g1 == 2'b00 && gn1 < 8) begin
         gh1[gn1] = g_dut[1].grant;
         gn1++;
      end
      prev_g0 = g_dut[0].grant;
      prev_g1 = g_dut[1].grant;
      @(posedge clk);
      #1;
      if (!hold_rd) begin
         if (hs_m0ar) m0_arvalid = 1'b0;
         if (hs_m1ar) m1_arvalid = 1'b0;
      end
      if (hs_aw) m1_awvalid = 1'b0;
      if (hs_w)  m1_wvalid  = 1'b0;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      hold_rd    = 1'b0;
      m0_arvalid = 1'b0;
      m1_arvalid = 1'b0;
      m1_awvalid = 1'b0;
      m1_wvalid  = 1'b0;
      m0_rready  = 1'b1;
      m1_rready  = 1'b1;
      m1_bready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
   endtask

   initial begin
      hold_rd    = 1'b0;
      clear_obs();
      // ---------------- Reset with every master requesting ----------------
      m0_araddr  = 32'h8000_0000;
      m1_araddr  = 32'h0000_1000;
      m1_awaddr  = 32'h8000_0010;
      m1_wdata   = 32'h1234_5678;
      m1_wstrb   = 4'b0011;
      m0_arvalid = 1'b1;
      m1_arvalid = 1'b1;
      m1_awvalid = 1'b1;
      m1_wvalid  = 1'b1;
      m0_rready  = 1'b1;
      m1_rready  = 1'b1;
      m1_bready  = 1'b1;
      rst        = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_vr_rr",  {20'd0, g_dut[0].vr}, 32'd0);
      check("rst_gnt_rr", {30'd0, g_dut[0].grant}, 32'd0);
      check("rst_vr_fp",  {20'd0, g_dut[1].vr}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("first_gnt_rr", {30'd0, g_dut[0].grant}, 32'd1);
      check("first_gnt_fp", {30'd0, g_dut[1].grant}, 32'd3);

      // ---------------- IFU-only read ----------------
      do_reset();
      m0_araddr  = 32'h8000_0000;
      m0_arvalid = 1'b1;
      for (int c = 0; c < 20 && !m0_r_done; c++) step();
      repeat (2) step();
      check("if_rd_done",  {31'd0, m0_r_done}, 32'd1);
      check("if_rvalid_n", m0_rv_cnt, 32'd1);
      check("if_rdata",    m0_rdata_obs, 32'hDEAD_BEEF);
      check("if_rresp",    {30'd0, m0_rresp_obs}, 32'd0);
      check("if_araddr",   ar_addr_obs, 32'h8000_0000);
      check("if_m1_quiet", {31'd0, m1_act}, 32'd0);
      check("if_gnt_seq",  {gn0[3:0], 2'b00, gh0[0]}, {4'd1, 2'b00, 2'b01});

      // ---------------- Round-robin vs fixed priority tie ----------------
      do_reset();
      hold_rd    = 1'b1;
      m0_araddr  = 32'h8000_0000;
      m1_araddr  = 32'h0000_1000;
      m0_arvalid = 1'b1;
      m1_arvalid = 1'b1;
      for (int c = 0; c < 60 && (gn0 < 4 || gn1 < 4); c++) step();
      check("rr_gnt_seq", {24'd0, gh0[0], gh0[1], gh0[2], gh0[3]}, 32'b01_10_01_10);
      check("fp_gnt_seq", {24'd0, gh1[0], gh1[1], gh1[2], gh1[3]}, 32'b10_10_10_10);

      // ---------------- LSU write with delayed B ready ----------------
      do_reset();
      m1_bready  = 1'b0;
      m1_awaddr  = 32'h8000_0010;
      m1_wdata   = 32'h1234_5678;
      m1_wstrb   = 4'b0011;
      m1_awvalid = 1'b1;
      m1_wvalid  = 1'b1;
      for (int c = 0; c < 30 && !m1_b_done; c++) begin
         step();
         if (b_stall >= 3) m1_bready = 1'b1;
      end
      check("wr_done",      {31'd0, m1_b_done}, 32'd1);
      check("wr_both_seen", {31'd0, both_seen}, 32'd1);
      check("wr_awaddr",    g_dut[0].cap_awaddr, 32'h8000_0010);
      check("wr_wdata",     g_dut[0].cap_wdata, 32'h1234_5678);
      check("wr_wstrb",     {28'd0, g_dut[0].cap_wstrb}, 32'h3);
      check("wr_bresp",     {30'd0, bresp_obs}, 32'd0);
      check("wr_stall",     b_stall, 32'd3);
      check("wr_bvalid_n",  m1_bv_cnt, 32'd4);
      check("wr_gnt_cycles", wr_gnt_cnt, 32'd5);
      @(negedge clk);
      check("wr_exit_gnt",  {30'd0, g_dut[0].grant}, 32'd0);
      @(posedge clk);
      #1;

      // ---------------- Reset in the middle of an IFU read ----------------
      do_reset();
      m0_rready  = 1'b0;
      m0_araddr  = 32'h8000_0000;
      m0_arvalid = 1'b1;
      repeat (2) step();
      @(negedge clk);
      check("mid_pre_rvalid", {31'd0, g_dut[0].m0_rvalid}, 32'd1);
      check("mid_pre_gnt",    {30'd0, g_dut[0].grant}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_vr",  {20'd0, g_dut[0].vr}, 32'd0);
      check("mid_rst_gnt", {30'd0, g_dut[0].grant}, 32'd0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      m0_arvalid = 1'b0;
      m0_rready  = 1'b1;
      clear_obs();
      m1_araddr  = 32'h0000_1000;
      m1_arvalid = 1'b1;
      for (int c = 0; c < 20 && !m1_r_done; c++) step();
      check("ls_rd_done",  {31'd0, m1_r_done}, 32'd1);
      check("ls_rvalid_n", m1_rv_cnt, 32'd1);
      check("ls_rdata",    m1_rdata_obs, 32'hFFFF_EFFF);
      check("ls_rresp",    {30'd0, m1_rresp_obs}, 32'd1);
      check("ls_gnt",      {30'd0, gh0[0]}, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
